skid_buffer: RTL

Two-entry elastic pipeline register that terminates a valid/ready handshake on its input side and re-drives it on its output side. It is the backpressure-aware counterpart of the plain enable-driven pipeline flops: a producer stage writes into it, and a consumer stage drains it at its own pace. `in_ready` and `out_valid` depend only on internal state, so no combinational path runs between the two sides. Sustained throughput is one beat per cycle.

---
 rtl/skid_buffer_if.sv | 35 +++
 rtl/skid_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/skid_buffer_if.sv
// Valid/ready handshake bundle for skid_buffer: producer side (in_*),
// consumer side (out_*) and the occupancy count.
interface skid_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    // Environment view: drives the producer offer and consumer ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    // Buffer view: terminates the input handshake and re-drives the output.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry elastic pipeline register. The main register feeds out_data and
// the skid register absorbs the one extra beat that arrives when the consumer
// stalls. in_ready/out_valid/count decode registered state only, so there is
// no combinational path between the producer and consumer sides.
module skid_buffer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_ready;
    logic w_out_valid;
    logic [1:0] w_count;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Decode handshake outputs from the registered state; the unused
    // encoding neither accepts nor presents a beat until it recovers.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_count     = 2'd0;
        case (r_state)
            ST_EMPTY: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
                w_count     = 2'd0;
            end
            ST_BUSY: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b1;
                w_count     = 2'd1;
            end
            ST_FULL: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
                w_count     = 2'd2;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_count     = 2'd0;
            end
        endcase
    end

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    // Next state and data-register load strobes; flush discards both fires.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid  = 1'b1;
                        w_state_next = ST_FULL;
                    end else if (w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ST_BUSY;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with asynchronous reset to EMPTY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data registers load only on accepted beats, skid promotion, or flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else if (flush) begin
            r_main <= RESET_VALUE;
            r_skid <= RESET_VALUE;
        end else begin
            if (w_load_main_in) begin
                r_main <= bus.in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.count     = w_count;
    assign bus.out_data  = r_main;

endmodule
